// File: rtl/clk_mon_pkg.sv
// Shared definitions for the divided-clock frequency monitor.
//
// Contents:
//   CLK_MON_DEFAULT_CW - default width of the measurement counters
//   clkMonState_e      - monitor state (IDLE, ACQ, LOCKED, LOST)
//   absDiff            - unsigned absolute difference used for tolerance tests
package clk_mon_pkg;

  localparam int unsigned CLK_MON_DEFAULT_CW = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } clkMonState_e;

  // Distance between a measurement and its expected value, without relying
  // on signed arithmetic.
  function automatic int unsigned absDiff(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
//
// Ports:
//   clk_i - destination clock
//   rst_i - asynchronous active-high reset, clears both flops to 0
//   d_i   - asynchronous input bit
//   q_o   - synchronised output, two destination cycles behind d_i
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // The first flop may go metastable; the second gives it a full cycle to
  // settle before anything downstream looks at the value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clk_freq_monitor.sv
// Checks that a divided clock has the expected period and high time.
// The monitored clock is synchronised into the clk_in domain. Its period and
// high time are counted in clk_in cycles. The monitor reports lock after
// enough consecutive good samples, and reports loss when rising edges stop.
//
// Ports:
//   clk_in       - system clock
//   rst          - asynchronous active-high reset
//   mon_clk      - monitored clock, treated as asynchronous data
//   period_o     - last measured period (clk_in cycles)
//   high_o       - last measured high time (clk_in cycles)
//   sample_valid - one-cycle pulse when period_o/high_o update
//   locked       - high while the waveform is locked
//   lost         - high while the monitored clock is considered lost
//   err_cnt      - saturating count of bad samples
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned CW         = CLK_MON_DEFAULT_CW,
  parameter int unsigned EXP_PERIOD = 4,
  parameter int unsigned EXP_HIGH   = 2,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          mon_clk,
  output logic [CW-1:0] period_o,
  output logic [CW-1:0] high_o,
  output logic          sample_valid,
  output logic          locked,
  output logic          lost,
  output logic [CW-1:0] err_cnt
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          monS;
  logic          monD_q;
  logic          rise;
  logic          fall;
  logic          sampleEvt;
  logic          sampleGood;
  logic          timeoutHit;

  logic [CW-1:0] perCnt_q,  perCnt_d;
  logic [CW-1:0] highCnt_q, highCnt_d;
  logic [CW-1:0] highCap_q, highCap_d;
  logic [CW-1:0] goodCnt_q, goodCnt_d;
  logic [CW-1:0] period_q,  period_d;
  logic [CW-1:0] high_q,    high_d;
  logic [CW-1:0] errCnt_q,  errCnt_d;
  logic          seen_q,    seen_d;
  logic          valid_q,   valid_d;
  logic          locked_q,  locked_d;
  logic          lost_q,    lost_d;

  clkMonState_e  state_q,   state_d;

  sync_2ff uMonSync (
    .clk_i (clk_in),
    .rst_i (rst),
    .d_i   (mon_clk),
    .q_o   (monS)
  );

  // One more flop behind the synchroniser gives the previous level, so the
  // edges can be found by comparing the current level with the previous one.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      monD_q <= 1'b0;
    end else begin
      monD_q <= monS;
    end
  end

  assign rise = monS & ~monD_q;
  assign fall = ~monS & monD_q;

  // The first rise after reset or after loss only starts a measurement, so a
  // rise counts as a sample only once an earlier rise has been seen.
  assign sampleEvt  = rise & seen_q;
  assign sampleGood = (absDiff(32'(perCnt_q), EXP_PERIOD) <= TOL) &&
                      (absDiff(32'(highCap_q), EXP_HIGH) <= TOL);

  // A rise in the same cycle always wins over the timeout.
  assign timeoutHit = (32'(perCnt_q) >= TIMEOUT) && !rise;

  // Measurement datapath. Both counters restart at 1 on a rise, so that
  // the value held just before the next rise is the full interval. A stuck
  // clock drives the counters to all-ones, where they stay. The high time is
  // frozen at the falling edge and held until the sample that reports it.
  always_comb begin
    perCnt_d  = perCnt_q;
    highCnt_d = highCnt_q;
    highCap_d = highCap_q;
    period_d  = period_q;
    high_d    = high_q;
    errCnt_d  = errCnt_q;
    valid_d   = 1'b0;

    if (rise) begin
      perCnt_d = CNT_ONE;
    end else if (perCnt_q != CNT_MAX) begin
      perCnt_d = perCnt_q + CNT_ONE;
    end

    if (rise) begin
      highCnt_d = CNT_ONE;
    end else if (monS && (highCnt_q != CNT_MAX)) begin
      highCnt_d = highCnt_q + CNT_ONE;
    end

    if (fall) begin
      highCap_d = highCnt_q;
    end

    if (sampleEvt) begin
      valid_d  = 1'b1;
      period_d = perCnt_q;
      high_d   = highCap_q;
      if (!sampleGood && (errCnt_q != CNT_MAX)) begin
        errCnt_d = errCnt_q + CNT_ONE;
      end
    end
  end

  // Lock/loss state machine. Any entry into ACQ restarts the count of good
  // samples. Entering LOST forgets the previous rise, so the first rise
  // after recovery is not treated as a sample. The status outputs are
  // decoded from the next state, so they change on the same edge as the
  // state does.
  always_comb begin
    state_d   = state_q;
    goodCnt_d = goodCnt_q;
    seen_d    = seen_q | rise;

    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d   = ST_ACQ;
          goodCnt_d = '0;
        end else if (timeoutHit) begin
          state_d = ST_LOST;
        end
      end
      ST_ACQ: begin
        if (sampleEvt) begin
          if (!sampleGood) begin
            goodCnt_d = '0;
          end else if ((32'(goodCnt_q) + 32'd1) >= LOCK_COUNT) begin
            state_d   = ST_LOCKED;
            goodCnt_d = '0;
          end else begin
            goodCnt_d = goodCnt_q + CNT_ONE;
          end
        end else if (timeoutHit) begin
          state_d = ST_LOST;
        end
      end
      ST_LOCKED: begin
        if (sampleEvt && !sampleGood) begin
          state_d   = ST_ACQ;
          goodCnt_d = '0;
        end else if (timeoutHit) begin
          state_d = ST_LOST;
        end
      end
      ST_LOST: begin
        if (rise) begin
          state_d   = ST_ACQ;
          goodCnt_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_d == ST_LOST) && (state_q != ST_LOST)) begin
      seen_d = 1'b0;
    end

    locked_d = (state_d == ST_LOCKED);
    lost_d   = (state_d == ST_LOST);
  end

  // All measurement, status and FSM registers. Reset clears them at once,
  // even partway through a measurement.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      perCnt_q  <= '0;
      highCnt_q <= '0;
      highCap_q <= '0;
      goodCnt_q <= '0;
      period_q  <= '0;
      high_q    <= '0;
      errCnt_q  <= '0;
      seen_q    <= 1'b0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      perCnt_q  <= perCnt_d;
      highCnt_q <= highCnt_d;
      highCap_q <= highCap_d;
      goodCnt_q <= goodCnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      errCnt_q  <= errCnt_d;
      seen_q    <= seen_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      lost_q    <= lost_d;
    end
  end

  assign period_o     = period_q;
  assign high_o       = high_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;
  assign lost         = lost_q;
  assign err_cnt      = errCnt_q;

endmodule
